mac_stg5_lanes: RTL

- Parametrised successor to the MAC stage-5 normaliser.
- Takes LANES independent normalised partial results (leading-1 sum, exponent terms, sign) and produces packed floating-point conv outputs.
- Adds selectable rounding, overflow/underflow saturation with flags, a valid/ready backpressure pipeline (replacing the inhibit stall), and saturating event counters.
- Sits between the MAC stage-4 normalise/align stage and the conv output buffer.

---
 rtl/mac_stg5_lanes.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mac_stg5_lanes.sv
// rtl/mac_stg5_lanes.sv - multi-lane MAC stage-5 normaliser: round, saturate, pack, with valid/ready pipeline
module mac_stg5_lanes #(
    parameter int LANES     = 4,
    parameter int EXP_IN_W  = 6,
    parameter int SUM_W     = 14,
    parameter int DIFF_W    = 5,
    parameter int EXP_OUT_W = 5,
    parameter int MAN_W     = 10,
    parameter int CNT_W     = 16
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic                                   i_valid,
    output logic                                   o_ready,
    input  logic [LANES*EXP_IN_W-1:0]              i_max_exp,
    input  logic [LANES*SUM_W-1:0]                 i_norm_sum,
    input  logic [LANES*DIFF_W-1:0]                i_exp_diff,
    input  logic [LANES-1:0]                       i_exp_carry,
    input  logic [LANES-1:0]                       i_sgn,
    input  logic                                   i_rnd_mode,
    output logic                                   o_valid,
    input  logic                                   i_ready,
    output logic [LANES*(1+EXP_OUT_W+MAN_W)-1:0]   o_conv,
    output logic [LANES-1:0]                       o_ovf,
    output logic [LANES-1:0]                       o_unf,
    input  logic                                   i_cnt_clr,
    output logic [CNT_W-1:0]                       o_ovf_cnt,
    output logic [CNT_W-1:0]                       o_unf_cnt
);
    localparam int OUT_W = 1 + EXP_OUT_W + MAN_W;
    localparam int D     = SUM_W - 1 - MAN_W;
    localparam int EW    = EXP_IN_W + 2;
    localparam int PW    = $clog2(LANES + 1);
    localparam logic signed [EW-1:0] E_ZERO   = '0;
    localparam logic signed [EW-1:0] E_MAX    = EW'((1 << EXP_OUT_W) - 1);
    localparam logic [EXP_OUT_W-1:0] EXP_SAT  = EXP_OUT_W'((1 << EXP_OUT_W) - 2);
    localparam logic [CNT_W-1:0]     CNT_MAX  = '1;

    logic                        s1_v, s2_v, s2_load;
    logic [LANES*EXP_IN_W-1:0]   s1_max_exp;
    logic [LANES*SUM_W-1:0]      s1_norm_sum;
    logic [LANES*DIFF_W-1:0]     s1_exp_diff;
    logic [LANES-1:0]            s1_exp_carry, s1_sgn;
    logic                        s1_rnd;
    logic [LANES*OUT_W-1:0]      res_conv;
    logic [LANES-1:0]            res_ovf, res_unf;

    assign s2_load = ~s2_v | i_ready;
    assign o_ready = ~s1_v | s2_load;
    assign o_valid = s2_v;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_v         <= 1'b0;
            s1_max_exp   <= '0;
            s1_norm_sum  <= '0;
            s1_exp_diff  <= '0;
            s1_exp_carry <= '0;
            s1_sgn       <= '0;
            s1_rnd       <= 1'b0;
        end else begin
            if (o_ready) s1_v <= i_valid;
            if (i_valid && o_ready) begin
                s1_max_exp   <= i_max_exp;
                s1_norm_sum  <= i_norm_sum;
                s1_exp_diff  <= i_exp_diff;
                s1_exp_carry <= i_exp_carry;
                s1_sgn       <= i_sgn;
                s1_rnd       <= i_rnd_mode;
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [SUM_W-1:0]      ns;
        logic [SUM_W-2:0]      f;
        logic [DIFF_W-1:0]     dsel;
        logic [MAN_W-1:0]      m_raw, m;
        logic                  rup, rc;
        logic signed [EW-1:0]  e;
        logic [OUT_W-1:0]      lane_conv;
        logic                  lane_ovf, lane_unf;

        assign ns    = s1_norm_sum[k*SUM_W +: SUM_W];
        assign f     = ns[SUM_W-2:0];
        assign m_raw = f[SUM_W-2:D];
        assign dsel  = s1_exp_diff[k*DIFF_W +: DIFF_W];

        // guard/sticky only exist when the fraction is wider than the mantissa
        if (D >= 2) begin : g_rne
            assign rup = ~s1_rnd & f[D-1] & ((|f[D-2:0]) | m_raw[0]);
        end else if (D == 1) begin : g_rne1
            assign rup = ~s1_rnd & f[0] & m_raw[0];
        end else begin : g_nornd
            assign rup = 1'b0;
        end

        assign {rc, m} = {1'b0, m_raw} + (MAN_W+1)'(rup);

        assign e = $signed({2'b00, s1_max_exp[k*EXP_IN_W +: EXP_IN_W]})
                 + $signed({{(EW-1){1'b0}}, s1_exp_carry[k]})
                 + $signed({{(EW-DIFF_W){dsel[DIFF_W-1]}}, dsel})
                 + $signed({{(EW-1){1'b0}}, rc});

        always_comb begin
            lane_ovf  = 1'b0;
            lane_unf  = 1'b0;
            lane_conv = {s1_sgn[k], {EXP_OUT_W{1'b0}}, {MAN_W{1'b0}}};
            if (ns[SUM_W-1]) begin
                if (e <= E_ZERO) begin
                    lane_unf = 1'b1;
                end else if (e >= E_MAX) begin
                    lane_ovf  = 1'b1;
                    lane_conv = {s1_sgn[k], EXP_SAT, {MAN_W{1'b1}}};
                end else begin
                    lane_conv = {s1_sgn[k], e[EXP_OUT_W-1:0], m};
                end
            end
        end

        assign res_conv[k*OUT_W +: OUT_W] = lane_conv;
        assign res_ovf[k] = lane_ovf;
        assign res_unf[k] = lane_unf;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s2_v   <= 1'b0;
            o_conv <= '0;
            o_ovf  <= '0;
            o_unf  <= '0;
        end else if (s2_load) begin
            s2_v <= s1_v;
            if (s1_v) begin
                o_conv <= res_conv;
                o_ovf  <= res_ovf;
                o_unf  <= res_unf;
            end
        end
    end

    function automatic logic [PW-1:0] popc(input logic [LANES-1:0] v);
        logic [PW-1:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) n = n + PW'(v[i]);
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [PW-1:0] n);
        logic [CNT_W+PW-1:0] s;
        s = {{PW{1'b0}}, c} + {{CNT_W{1'b0}}, n};
        return (s > {{PW{1'b0}}, CNT_MAX}) ? CNT_MAX : s[CNT_W-1:0];
    endfunction

    // clear beats a same-cycle increment; that cycle's events are dropped
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ovf_cnt <= '0;
            o_unf_cnt <= '0;
        end else if (i_cnt_clr) begin
            o_ovf_cnt <= '0;
            o_unf_cnt <= '0;
        end else if (s2_v && i_ready) begin
            o_ovf_cnt <= sat_add(o_ovf_cnt, popc(o_ovf));
            o_unf_cnt <= sat_add(o_unf_cnt, popc(o_unf));
        end
    end
endmodule
